resta_operand_sequencer: RTL and testbench
==========================================

// Module: resta_operand_sequencer
// PURPOSE
//   Upstream/downstream sequencer for the M-bit ripple subtractor.
//   Captures operands A then B from switches on two debounced load-button presses and drives them to the subtractor.
//   Waits a settle window, then registers the result and C/N/V/Z flags for display.
//   Sits between board I/O (switches, button) and the 7-segment/LED display stage.
// PARAMETERS
//   M              4   operand/result width, must be >= 2
//   SETTLE_CYCLES  2   clock edges between op_b load and result capture, must be >= 1
// PORTS
//   clk           in   1  system clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   data_in       in   M  operand value from switches
//   load_btn      in   1  raw push-button, active high, asynchronous to clk
//   clear         in   1  synchronous clear, active high
//   op_a          out  M  operand A to subtractor
//   op_b          out  M  operand B to subtractor
//   r_in          in   M  subtractor result R
//   c_in          in   1  subtractor carry out (1 = no borrow)
//   n_in          in   1  subtractor negative flag
//   v_in          in   1  subtractor overflow flag
//   z_in          in   1  subtractor zero flag
//   result        out  M  registered R
//   flag_c        out  1  registered C
//   flag_n        out  1  registered N
//   flag_v        out  1  registered V
//   flag_z        out  1  registered Z
//   result_valid  out  1  result/flags hold a completed A-B
//   busy          out  1  high in S_SETTLE
// BEHAVIOUR
//   - Reset (rst_n=0, async):
//       - all outputs 0; sync/edge flops 0; counter 0
//       - state S_WAIT_A
//   - Button input: load_btn -> sync1 -> sync2 -> prev; load_pulse = sync2 & ~prev.
//       - One pulse per press regardless of hold length.
//       - Action occurs on the 3rd rising edge after load_btn rises.
//   - FSM (2-bit):
//       - S_WAIT_A
//           - on load_pulse: op_a <= data_in -> S_WAIT_B
//       - S_WAIT_B
//           - on load_pulse: op_b <= data_in, cnt <= 0 -> S_SETTLE
//       - S_SETTLE
//           - busy=1; load_pulse ignored
//           - cnt increments each edge
//           - at the edge where cnt == SETTLE_CYCLES-1: result/flags <= r_in/c_in/n_in/v_in/z_in, result_valid <= 1 -> S_DONE
//       - S_DONE
//           - outputs held
//           - on load_pulse: op_a <= data_in, result_valid <= 0 -> S_WAIT_B
//   - Latency: result captured exactly SETTLE_CYCLES edges after the op_b load edge.
//   - Flags are latched as supplied; no recomputation. op_a/op_b are stable throughout S_SETTLE.
//   - clear: priority over load_pulse in every state.
//       - Next edge: op_a, op_b, result, flags, result_valid, cnt <= 0 -> S_WAIT_A.
//       - Sync flops are not cleared.
//   - rst_n asserted mid-operation (any state): immediate return to reset values; no partial capture.
//   - Unused state encoding -> S_WAIT_A.
// TESTING (M=4, SETTLE_CYCLES=2; bench model: R=A-B mod 16, C=(A>=B), N=R[3], V=signed ovf, Z=(R==0))
//   1. Reset with btn idle -> all outputs 0, busy=0; no load for 10 cycles without a press.
//   2. data_in=7 press, data_in=3 press -> op_a=7, op_b=3; 2 edges later result=4, C=1 N=0 V=0 Z=0, valid=1.
//   3. 3 then 5 -> result=4'hE, C=0, N=1, V=0, Z=0; 5 then 5 -> result=0, Z=1, C=1.
//   4. 4'sd7 - 4'sd(-1): A=7, B=4'hF -> result=8, V=1, N=1, C=0.
//   5. Button held 20 cycles in S_WAIT_A -> exactly one load, state S_WAIT_B; press during S_SETTLE -> ignored.
//   6. clear in S_SETTLE and rst_n low in S_WAIT_B -> all outputs 0, S_WAIT_A, valid never rises.

Source files
------------

// File: rtl/resta_operand_sequencer.sv
// Operand sequencer for the M-bit ripple subtractor: loads A then B on debounced
// button presses, waits a settle window, then latches the result and flags for display.
module resta_operand_sequencer #(
    parameter int M             = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] data_in,
    input  logic         load_btn,
    input  logic         clear,
    output logic [M-1:0] op_a,
    output logic [M-1:0] op_b,
    input  logic [M-1:0] r_in,
    input  logic         c_in,
    input  logic         n_in,
    input  logic         v_in,
    input  logic         z_in,
    output logic [M-1:0] result,
    output logic         flag_c,
    output logic         flag_n,
    output logic         flag_v,
    output logic         flag_z,
    output logic         result_valid,
    output logic         busy
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_A = 2'd0,
        S_WAIT_B = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           sync1_q, sync2_q, prev_q;
    logic           load_pulse;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [M-1:0]   op_a_q, op_a_d;
    logic [M-1:0]   op_b_q, op_b_d;
    logic [M-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;   // {C, N, V, Z}
    logic           valid_q, valid_d;

    // Two-flop synchronizer plus edge detector: one pulse per press.
    assign load_pulse = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT_A;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= load_btn;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        if (clear) begin
            state_d  = S_WAIT_A;
            cnt_d    = '0;
            op_a_d   = '0;
            op_b_d   = '0;
            result_d = '0;
            flags_d  = '0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_A: begin
                    if (load_pulse) begin
                        op_a_d  = data_in;
                        state_d = S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (load_pulse) begin
                        op_b_d  = data_in;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = r_in;
                        flags_d  = {c_in, n_in, v_in, z_in};
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (load_pulse) begin
                        op_a_d  = data_in;
                        valid_d = 1'b0;
                        state_d = S_WAIT_B;
                    end
                end
                default: state_d = S_WAIT_A;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q == S_SETTLE);
        op_a         = op_a_q;
        op_b         = op_b_q;
        result       = result_q;
        {flag_c, flag_n, flag_v, flag_z} = flags_q;
        result_valid = valid_q;
    end

endmodule

// File: tb/tb_resta_operand_sequencer.sv
// Randomized bench for resta_operand_sequencer: a transaction-level model predicts
// all outputs every cycle; directed literal checks pin the model to known results.
module tb_resta_operand_sequencer;

    localparam int M      = 4;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [M-1:0] data_in;
    logic         load_btn;
    logic         clear;
    logic [M-1:0] op_a, op_b, r_in, result;
    logic         c_in, n_in, v_in, z_in;
    logic         flag_c, flag_n, flag_v, flag_z, result_valid, busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    // Environment: the combinational subtractor the sequencer feeds.
    assign r_in = op_a - op_b;
    assign c_in = (op_a >= op_b);
    assign n_in = r_in[M-1];
    assign v_in = (op_a[M-1] != op_b[M-1]) && (r_in[M-1] != op_a[M-1]);
    assign z_in = (r_in == '0);

    resta_operand_sequencer #(.M(M), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_btn(load_btn), .clear(clear),
        .op_a(op_a), .op_b(op_b), .r_in(r_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
        .z_in(z_in), .result(result), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
        .flag_z(flag_z), .result_valid(result_valid), .busy(busy)
    );

    // Expected {C,N,V,Z,R} of A-B from integer arithmetic.
    function automatic logic [7:0] sub4(input logic [3:0] a, input logic [3:0] b);
        int sa, sb, d;
        logic [3:0] r;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        d  = sa - sb;
        r  = a - b;
        return {(a >= b), r[3], (d > 7 || d < -8), (r == 4'd0), r};
    endfunction

    // Reference model: phase 0=need A, 1=need B, 2=settling, 3=done.
    int         m_phase = 0;
    int         m_left  = 0;
    logic [3:0] m_a = '0, m_b = '0, m_r = '0, m_fl = '0;
    logic       m_valid = 1'b0;
    logic [2:0] m_hist = '0;   // btn samples at the last three edges, [0] newest
    logic       m_pulse;
    assign m_pulse = m_hist[1] & ~m_hist[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_a <= '0; m_b <= '0; m_r <= '0; m_fl <= '0;
            m_valid <= 1'b0; m_hist <= '0;
        end else begin
            m_hist <= {m_hist[1:0], load_btn};
            if (clear) begin
                m_phase <= 0; m_a <= '0; m_b <= '0; m_r <= '0; m_fl <= '0; m_valid <= 1'b0;
            end else begin
                case (m_phase)
                    0: if (m_pulse) begin m_a <= data_in; m_phase <= 1; end
                    1: if (m_pulse) begin m_b <= data_in; m_left <= SETTLE; m_phase <= 2; end
                    2: begin
                        if (m_left == 1) begin
                            {m_fl, m_r} <= sub4(m_a, m_b);
                            m_valid <= 1'b1;
                            m_phase <= 3;
                        end else m_left <= m_left - 1;
                    end
                    default: if (m_pulse) begin m_a <= data_in; m_valid <= 1'b0; m_phase <= 1; end
                endcase
            end
        end
    end

    logic [17:0] act_v, exp_v;
    assign act_v = {op_a, op_b, result, flag_c, flag_n, flag_v, flag_z, result_valid, busy};
    assign exp_v = {m_a, m_b, m_r, m_fl, m_valid, (m_phase == 2)};

    always @(negedge clk) begin
        if (run) begin
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t got a=%h b=%h r=%h cnvz=%b v=%b busy=%b expected a=%h b=%h r=%h cnvz=%b v=%b busy=%b",
                         $time, op_a, op_b, result, {flag_c, flag_n, flag_v, flag_z}, result_valid, busy,
                         m_a, m_b, m_r, m_fl, m_valid, (m_phase == 2));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        data_in  = d;
        load_btn = 1'b1;
        repeat (hold) tick();
        load_btn = 1'b0;
        repeat (4) tick();
    endtask

    function automatic int flags();
        return int'({flag_c, flag_n, flag_v, flag_z});
    endfunction

    initial begin
        rst_n = 1'b0; load_btn = 1'b0; clear = 1'b0; data_in = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        run   = 1'b1;
        chk("reset_outputs", int'(act_v), 0);
        data_in = 4'd9;
        repeat (10) tick();
        chk("idle_no_load_a", int'(op_a), 0);
        chk("idle_busy", int'(busy), 0);

        press(4'd7, 1);
        chk("load_a_7", int'(op_a), 7);
        chk("valid_after_a", int'(result_valid), 0);
        press(4'd3, 1);
        chk("load_b_3", int'(op_b), 3);
        chk("res_7_3", int'(result), 4);
        chk("flags_7_3", flags(), 4'b1000);
        chk("valid_7_3", int'(result_valid), 1);

        press(4'd3, 1);
        chk("reload_a_clears_valid", int'(result_valid), 0);
        press(4'd5, 1);
        chk("res_3_5", int'(result), 4'hE);
        chk("flags_3_5", flags(), 4'b0100);
        press(4'd5, 1); press(4'd5, 1);
        chk("res_5_5", int'(result), 0);
        chk("flags_5_5", flags(), 4'b1001);
        press(4'd7, 1); press(4'hF, 1);
        chk("res_7_m1", int'(result), 8);
        chk("flags_7_m1", flags(), 4'b0110);

        // Long hold loads once; a press landing in the settle window is ignored.
        press(4'd9, 20);
        chk("hold_one_load", int'(op_a), 9);
        chk("hold_valid_low", int'(result_valid), 0);
        data_in = 4'd2; load_btn = 1'b1; tick();
        load_btn = 1'b0; tick();
        load_btn = 1'b1; tick();
        chk("settle_busy", int'(busy), 1);
        chk("settle_op_b", int'(op_b), 2);
        load_btn = 1'b0;
        repeat (5) tick();
        chk("ignored_press_op_a", int'(op_a), 9);
        chk("res_9_2", int'(result), 7);
        chk("flags_9_2", flags(), 4'b1010);
        chk("busy_done", int'(busy), 0);

        // clear during settle
        press(4'd1, 1);
        data_in = 4'd1; load_btn = 1'b1; tick();
        load_btn = 1'b0; tick(); tick();
        chk("pre_clear_busy", int'(busy), 1);
        clear = 1'b1; tick();
        clear = 1'b0;
        chk("clear_outputs", int'(act_v), 0);
        repeat (5) begin
            tick();
            chk("valid_after_clear", int'(result_valid), 0);
        end

        // async reset in S_WAIT_B
        press(4'd4, 1);
        chk("pre_reset_a", int'(op_a), 4);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(act_v), 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("valid_after_reset", int'(result_valid), 0);

        for (int i = 0; i < 1500; i++) begin
            data_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) load_btn = ~load_btn;
            clear = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        clear = 1'b0;
        tick();

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
